timer_apb_mc: RTL and testbench

Parametrised multi-channel successor to the team's 8-bit APB timer: NUM_CH independent WIDTH-bit up/down counters behind a single zero-wait-state APB slave. Adds a wide prescaler, an auto-reload mode and per-channel interrupt lines, while keeping one-shot load, W1C status and reserved-region rules. Sits on the peripheral APB bus; `irq` goes to the interrupt controller.

---
 rtl/timer_mc_pkg.sv | 60 ++++++
 rtl/timer_apb_mc_if.sv | 23 ++
 rtl/timer_mc_channel.sv | 101 ++++++++++
 rtl/timer_apb_mc.sv | 79 +++++++
 tb/tb_timer_apb_mc.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_mc_pkg.sv
// Shared register map, TCR field layout and small helpers for the multi-channel APB timer.
package timer_mc_pkg;

  localparam logic [3:0] OFF_TDR  = 4'h0;
  localparam logic [3:0] OFF_TCR  = 4'h4;
  localparam logic [3:0] OFF_TCNT = 4'h8;
  localparam logic [3:0] OFF_TSR  = 4'hC;

  localparam int TCR_EN     = 0;
  localparam int TCR_LOAD   = 1;
  localparam int TCR_DN     = 2;
  localparam int TCR_ARL    = 3;
  localparam int TCR_CKS    = 4;
  localparam int TCR_OVF_IE = 8;
  localparam int TCR_UDF_IE = 9;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef logic [2:0] cks_t;

  // Only the persistent TCR fields; the load pulse is never stored.
  typedef struct packed {
    logic udf_ie;
    logic ovf_ie;
    cks_t cks;
    logic arl;
    logic dn;
    logic en;
  } tcr_t;

  function automatic tcr_t tcr_unpack(input logic [9:0] w);
    tcr_t t;
    t.en     = w[TCR_EN];
    t.dn     = w[TCR_DN];
    t.arl    = w[TCR_ARL];
    t.cks    = w[TCR_CKS +: 3];
    t.ovf_ie = w[TCR_OVF_IE];
    t.udf_ie = w[TCR_UDF_IE];
    return t;
  endfunction

  function automatic logic [31:0] tcr_pack(input tcr_t t);
    logic [31:0] w;
    w               = '0;
    w[TCR_EN]       = t.en;
    w[TCR_DN]       = t.dn;
    w[TCR_ARL]      = t.arl;
    w[TCR_CKS +: 3] = t.cks;
    w[TCR_OVF_IE]   = t.ovf_ie;
    w[TCR_UDF_IE]   = t.udf_ie;
    return w;
  endfunction

  // Terminal prescaler value for divide-by-2^cks.
  function automatic logic [6:0] psc_limit(input cks_t c);
    return 7'((8'd1 << c) - 8'd1);
  endfunction

endpackage

// File: rtl/timer_apb_mc_if.sv
// APB3 signal bundle between the peripheral bus and the timer block.
interface timer_apb_mc_if #(
  parameter int ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_mc_channel.sv
// One timer channel: prescaler, up/down counter with optional auto-reload, W1C flags and irq.
module timer_mc_channel
  import timer_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_tdr_i,
  input  logic        wr_tcr_i,
  input  logic        wr_tsr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tdr_o,
  output logic [31:0] tcr_o,
  output logic [31:0] tcnt_o,
  output logic [31:0] tsr_o,
  output logic        irq_o
);

  logic [WIDTH-1:0] tdr_q, tdr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  tcr_t             tcr_q, tcr_d;
  logic [6:0]       psc_q, psc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  tcr_t tcr_wr;
  logic load;
  logic tick;
  logic set_ovf;
  logic set_udf;
  logic unused_wdata;

  assign unused_wdata = ^wdata_i;

  always_comb begin
    tcr_wr  = tcr_unpack(wdata_i[9:0]);
    load    = wr_tcr_i & wdata_i[TCR_LOAD];
    tick    = tcr_q.en && (psc_q == psc_limit(tcr_q.cks));

    tdr_d   = wr_tdr_i ? wdata_i[WIDTH-1:0] : tdr_q;
    tcr_d   = wr_tcr_i ? tcr_wr : tcr_q;

    psc_d   = psc_q + 7'd1;
    if (tick || !tcr_q.en) psc_d = '0;
    if (wr_tcr_i && (tcr_wr.cks != tcr_q.cks)) psc_d = '0;

    // Load uses the TDR already held, so a same-transfer TDR write cannot race it.
    cnt_d   = cnt_q;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (load) begin
      cnt_d = tdr_q;
    end else if (tick) begin
      if (!tcr_q.dn) begin
        if (cnt_q == '1) begin
          cnt_d   = tcr_q.arl ? tdr_q : '0;
          set_ovf = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d   = tcr_q.arl ? tdr_q : '1;
          set_udf = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    // A flag raised on this edge wins over a concurrent write-1-to-clear.
    ovf_d = set_ovf | (ovf_q & ~(wr_tsr_i & wdata_i[TSR_OVF]));
    udf_d = set_udf | (udf_q & ~(wr_tsr_i & wdata_i[TSR_UDF]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tdr_q <= '0;
      tcr_q <= '0;
      cnt_q <= '0;
      psc_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tdr_q <= tdr_d;
      tcr_q <= tcr_d;
      cnt_q <= cnt_d;
      psc_q <= psc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign tdr_o  = 32'(tdr_q);
  assign tcr_o  = tcr_pack(tcr_q);
  assign tcnt_o = 32'(cnt_q);
  assign tsr_o  = {30'd0, udf_q, ovf_q};
  assign irq_o  = (ovf_q & tcr_q.ovf_ie) | (udf_q & tcr_q.udf_ie);

endmodule

// File: rtl/timer_apb_mc.sv
// Multi-channel APB timer: address decode, channel array, read mux and interrupt OR.
module timer_apb_mc
  import timer_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              pclk,
  input  logic              presetn,
  timer_apb_mc_if.slave     apb,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int CW = ADDR_W - 4;

  logic          access;
  logic          wr;
  logic [CW-1:0] ch_idx;
  logic [3:0]    offset;
  logic          unused_paddr;

  logic [31:0] tdr_rd  [NUM_CH];
  logic [31:0] tcr_rd  [NUM_CH];
  logic [31:0] tcnt_rd [NUM_CH];
  logic [31:0] tsr_rd  [NUM_CH];

  assign access       = apb.psel & apb.penable;
  assign wr           = access & apb.pwrite;
  assign ch_idx       = apb.paddr[ADDR_W-1:4];
  assign offset       = {apb.paddr[3:2], 2'b00};
  assign unused_paddr = ^apb.paddr[1:0];

  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;

  // Addresses past the last channel never match a channel index, so they fall through as no-ops.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = wr && (ch_idx == CW'(c));

    timer_mc_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_i    (pclk),
      .rst_ni   (presetn),
      .wr_tdr_i (hit && (offset == OFF_TDR)),
      .wr_tcr_i (hit && (offset == OFF_TCR)),
      .wr_tsr_i (hit && (offset == OFF_TSR)),
      .wdata_i  (apb.pwdata),
      .tdr_o    (tdr_rd[c]),
      .tcr_o    (tcr_rd[c]),
      .tcnt_o   (tcnt_rd[c]),
      .tsr_o    (tsr_rd[c]),
      .irq_o    (irq[c])
    );
  end

  always_comb begin
    apb.prdata = '0;
    if (access && !apb.pwrite) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == CW'(c)) begin
          case (offset)
            OFF_TDR:  apb.prdata = tdr_rd[c];
            OFF_TCR:  apb.prdata = tcr_rd[c];
            OFF_TCNT: apb.prdata = tcnt_rd[c];
            OFF_TSR:  apb.prdata = tsr_rd[c];
            default:  apb.prdata = '0;
          endcase
        end
      end
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_apb_mc.sv
// Directed bench for timer_apb_mc (NUM_CH=4, WIDTH=16, ADDR_W=12) with hand-computed expectations.
module tb_timer_apb_mc;

  logic       pclk;
  logic       presetn;
  logic [3:0] irq;
  logic       irq_any;

  int checks   = 0;
  int failures = 0;

  timer_apb_mc_if #(.ADDR_W(12)) apb ();

  timer_apb_mc #(
    .NUM_CH (4),
    .WIDTH  (16),
    .ADDR_W (12)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (apb),
    .irq     (irq),
    .irq_any (irq_any)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Full APB write; call just after a posedge, commit happens on the second posedge, returns 1ns later.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = a;
    apb.pwdata  = d;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(posedge pclk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  // Side-effect-free read sampled within one clock phase.
  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite  = 1'b0;
    apb.paddr   = a;
    #1;
    d = apb.prdata;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    presetn     = 1'b0;
    #2;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    check("rst_pready", 32'(apb.pready), 32'h1);
    check("rst_pslverr", 32'(apb.pslverr), 32'h0);
    check("rst_prdata_idle", apb.prdata, 32'h0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    step(1);

    // Reset values and reserved region
    for (int a = 0; a < 64; a += 4) begin
      rd_chk($sformatf("rst_rd_%02h", a), 12'(a), 32'h0);
      step(1);
    end
    rd_chk("oob_rd", 12'h044, 32'h0);
    wr(12'h044, 32'hFFFF_FFFF);
    rd_chk("oob_rd_after_wr", 12'h044, 32'h0);
    check("oob_pready", 32'(apb.pready), 32'h1);
    check("oob_pslverr", 32'(apb.pslverr), 32'h0);
    step(1);
    wr(12'h034, 32'hFFFF_FC80);
    rd_chk("tcr_reserved", 12'h034, 32'h0);
    rd_chk("tcnt_after_reserved", 12'h038, 32'h0);

    // Ch1: load 0xFFFD, count up divide-by-2 through overflow
    step(1);
    wr(12'h010, 32'h0000_FFFD);
    wr(12'h014, 32'h0000_0002);
    rd_chk("ch1_tcnt_loaded", 12'h018, 32'h0000_FFFD);
    rd_chk("ch1_tcr_load_reads0", 12'h014, 32'h0);
    step(1);
    wr(12'h014, 32'h0000_0011);
    rd_chk("ch1_c0", 12'h018, 32'h0000_FFFD);
    step(1);
    rd_chk("ch1_c1", 12'h018, 32'h0000_FFFD);
    step(1);
    rd_chk("ch1_c2", 12'h018, 32'h0000_FFFE);
    step(3);
    rd_chk("ch1_c5", 12'h018, 32'h0000_FFFF);
    rd_chk("ch1_c5_tsr", 12'h01C, 32'h0);
    step(1);
    rd_chk("ch1_c6", 12'h018, 32'h0000_0000);
    rd_chk("ch1_c6_tsr", 12'h01C, 32'h1);
    check("ch1_irq_masked", 32'(irq), 32'h0);
    step(1);
    wr(12'h014, 32'h0);
    wr(12'h01C, 32'h1);
    rd_chk("ch1_tsr_cleared", 12'h01C, 32'h0);

    // Ch0: count down with auto-reload and udf interrupt
    step(1);
    wr(12'h000, 32'h0000_0005);
    wr(12'h004, 32'h0000_0002);
    step(1);
    wr(12'h004, 32'h0000_020D);
    rd_chk("ch0_c0", 12'h008, 32'h5);
    rd_chk("ch0_tcr", 12'h004, 32'h0000_020D);
    step(5);
    rd_chk("ch0_c5", 12'h008, 32'h0);
    check("ch0_c5_irq", 32'(irq), 32'h0);
    step(1);
    rd_chk("ch0_c6_reload", 12'h008, 32'h5);
    rd_chk("ch0_c6_tsr", 12'h00C, 32'h2);
    check("ch0_c6_irq", 32'(irq), 32'h1);
    check("ch0_c6_irq_any", 32'(irq_any), 32'h1);
    wr(12'h00C, 32'h2);
    check("ch0_irq_cleared", 32'(irq), 32'h0);
    check("ch0_irq_any_cleared", 32'(irq_any), 32'h0);
    rd_chk("ch0_tcnt_after_clr", 12'h008, 32'h3);
    wr(12'h004, 32'h0);

    // Ch2: W1C of ovf on the same edge as the wrap
    step(1);
    wr(12'h020, 32'h0000_FFFC);
    wr(12'h024, 32'h0000_0002);
    step(1);
    wr(12'h024, 32'h0000_0101);
    step(2);
    wr(12'h02C, 32'h1);
    rd_chk("ch2_wrap", 12'h028, 32'h0);
    rd_chk("ch2_ovf_kept", 12'h02C, 32'h1);
    check("ch2_irq", 32'(irq), 32'h4);

    // Ch3: load on a tick edge with cks=3, then cks 3->0 mid-run
    step(1);
    wr(12'h030, 32'h0000_0100);
    step(1);
    wr(12'h034, 32'h0000_0031);
    step(7);
    rd_chk("ch3_c7", 12'h038, 32'h0);
    step(1);
    rd_chk("ch3_c8", 12'h038, 32'h1);
    step(6);
    wr(12'h034, 32'h0000_0033);
    rd_chk("ch3_load_on_tick", 12'h038, 32'h0000_0100);
    rd_chk("ch3_load_no_flag", 12'h03C, 32'h0);
    step(7);
    rd_chk("ch3_c23", 12'h038, 32'h0000_0100);
    step(1);
    rd_chk("ch3_c24", 12'h038, 32'h0000_0101);
    wr(12'h034, 32'h0000_0001);
    rd_chk("ch3_cks_chg", 12'h038, 32'h0000_0101);
    step(1);
    rd_chk("ch3_cks0_a", 12'h038, 32'h0000_0102);
    step(1);
    rd_chk("ch3_cks0_b", 12'h038, 32'h0000_0103);

    // Asynchronous reset while ch2 runs with its irq high
    step(1);
    check("pre_rst_irq", 32'(irq), 32'h4);
    #2;
    presetn = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_irq_any", 32'(irq_any), 32'h0);
    check("async_rst_prdata", apb.prdata, 32'h0);
    rd_chk("async_rst_tcnt2", 12'h028, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    step(5);
    rd_chk("post_rst_tcnt2", 12'h028, 32'h0);
    rd_chk("post_rst_tsr2", 12'h02C, 32'h0);
    rd_chk("post_rst_tcr2", 12'h024, 32'h0);
    wr(12'h024, 32'h0000_0001);
    rd_chk("re_en_c0", 12'h028, 32'h0);
    step(1);
    rd_chk("re_en_c1", 12'h028, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
